qdiv: RTL and testbench

- Sequential signed fixed-point divider in sign-magnitude Q format: bit N-1 is the sign, bits N-2..0 are the magnitude, and the low Q bits are fractional.
- Uses bit-serial restoring division, one quotient bit per clock.
- Used by datapath blocks that need a full-precision fixed-point quotient and can tolerate multi-cycle latency.

---
 rtl/qdiv_pkg.sv | 12 +
 rtl/qdiv_if.sv | 27 ++
 rtl/qdiv_step.sv | 28 ++
 rtl/qdiv.sv | 119 +++++++++++
 tb/tb_qdiv.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/qdiv_pkg.sv
// qdiv_pkg: shared types for the sign-magnitude fixed-point divider.
// Contents:
//   state_e - sequencing states of the divider (IDLE / LOAD / RUN)
package qdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/qdiv_if.sv
// qdiv_if: operand/result bundle of the divider.
// Signals:
//   dividend, divisor [N-1:0] - sign-magnitude operands (master -> slave)
//   start                     - level-sensitive load/restart (master -> slave)
//   quotient [N-1:0]          - registered sign-magnitude result (slave -> master)
//   complete                  - quotient holds the last finished result
//   overflow                  - result saturated or divisor was zero
interface qdiv_if #(
  parameter int N = 32
);
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         start;
  logic [N-1:0] quotient;
  logic         complete;
  logic         overflow;

  modport master (
    output dividend, divisor, start,
    input  quotient, complete, overflow
  );

  modport slave (
    input  dividend, divisor, start,
    output quotient, complete, overflow
  );
endinterface

// File: rtl/qdiv_step.sv
// qdiv_step: one combinational restoring-division step.
// Ports:
//   i_rem   [N-2:0] - current remainder (always below the divisor magnitude)
//   i_bit           - next working-dividend bit, MSB first
//   i_div   [N-2:0] - divisor magnitude
//   o_rem   [N-2:0] - remainder after this step
//   o_qbit          - quotient bit produced by this step
module qdiv_step #(
  parameter int N = 32
) (
  input  logic [N-2:0] i_rem,
  input  logic         i_bit,
  input  logic [N-2:0] i_div,
  output logic [N-2:0] o_rem,
  output logic         o_qbit
);

  logic [N-1:0] w_shift;
  logic [N-2:0] w_diff;

  // The shifted remainder needs one extra bit; after a successful subtract
  // the result is below the divisor again, so N-1 bits of difference suffice.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift[N-2:0] - i_div;
  assign o_qbit  = (w_shift >= {1'b0, i_div});
  assign o_rem   = o_qbit ? w_diff : w_shift[N-2:0];

endmodule

// File: rtl/qdiv.sv
// qdiv: sequential sign-magnitude Q-format divider, one quotient bit per clock.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, highest priority
//   bus  - qdiv_if slave: dividend, divisor, start in; quotient, complete,
//          overflow out (all outputs registered)
// A division takes N+Q-1 clocks with start low after the load; holding start
// high keeps reloading, and start mid-operation restarts with new operands.
module qdiv
  import qdiv_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic      clk,
  input  logic      rst,
  qdiv_if.slave     bus
);

  localparam int W  = N - 1 + Q;       // working dividend / raw quotient width
  localparam int CW = $clog2(N + Q);   // iteration counter width

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_dvd;              // working dividend, consumed MSB first
  logic [N-2:0]    r_rem;
  logic [W-1:0]    r_quo;              // raw quotient being built
  logic [N-2:0]    r_dsr;
  logic            r_sign;
  logic            r_dsr_zero;
  logic [N-1:0]    r_quotient;
  logic            r_complete;
  logic            r_overflow;

  logic [N-2:0]    w_rem_nxt;
  logic            w_qbit;
  logic [W-1:0]    w_quo_full;
  logic            w_ovf;
  logic [N-2:0]    w_mag;
  logic [N-1:0]    w_result;

  qdiv_step #(.N(N)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[W-1]),
    .i_div  (r_dsr),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_quo_full = {r_quo[W-2:0], w_qbit};

  // Result formatting, evaluated on the final iteration. A zero divisor makes
  // every step produce a 1 anyway; the explicit flag keeps it an overflow even
  // when Q=0 and the raw quotient would fit.
  // NOTE: every output of a combinational block gets a default first so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    w_ovf    = r_dsr_zero;
    w_mag    = w_quo_full[N-2:0];
    w_result = '0;
    if (|w_quo_full[W-1:N-1]) w_ovf = 1'b1;
    if (w_ovf) w_mag = '1;
    // No negative zero: the sign only survives a non-zero magnitude.
    w_result = {r_sign & (|w_mag), w_mag};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dsr      <= '0;
      r_sign     <= 1'b0;
      r_dsr_zero <= 1'b0;
      r_quotient <= '0;
      r_complete <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.start) begin
      // quotient deliberately keeps the previous result while loading.
      r_state    <= ST_LOAD;
      r_cnt      <= CW'(W);
      r_dvd      <= W'(bus.dividend[N-2:0]) << Q;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dsr      <= bus.divisor[N-2:0];
      r_sign     <= bus.dividend[N-1] ^ bus.divisor[N-1];
      r_dsr_zero <= (bus.divisor[N-2:0] == '0);
      r_complete <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD, ST_RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= r_dvd << 1;
          r_quo <= w_quo_full;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_quotient <= w_result;
            r_overflow <= w_ovf;
            r_complete <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_state    <= ST_RUN;
          end
        end
        default: ;  // IDLE: results hold until start or rst
      endcase
    end
  end

  assign bus.quotient = r_quotient;
  assign bus.complete = r_complete;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_qdiv.sv
// tb_qdiv: self-checking bench for qdiv (Q=15, N=32). Directed cases plus
// randomized operands compared against an arithmetic reference model.
module tb_qdiv;

  localparam int Q   = 15;
  localparam int N   = 32;
  localparam int LAT = N + Q - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  qdiv_if #(.N(N)) bus ();

  qdiv #(.Q(Q), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [N-1:0] last_q;
  logic         last_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division of the magnitudes, then saturation and
  // the sign rule.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic ovf);
    longint unsigned am, bm, m, maxm;
    am   = a[N-2:0];
    bm   = b[N-2:0];
    maxm = (64'd1 << (N - 1)) - 1;
    if (bm == 0) begin
      m   = maxm;
      ovf = 1'b1;
    end else begin
      m   = (am << Q) / bm;
      ovf = (m > maxm);
      if (ovf) m = maxm;
    end
    q = {(a[N-1] ^ b[N-1]) && (m != 0), m[N-2:0]};
  endfunction

  // Called at a negedge right after start has been dropped.
  task automatic wait_done(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] eq;
    logic         eo;
    model(a, b, eq, eo);
    repeat (LAT - 1) @(negedge clk);
    check({tag, "_busy"}, 64'(bus.complete), 64'd0);
    check({tag, "_qhold"}, 64'(bus.quotient), 64'(last_q));
    @(negedge clk);
    check({tag, "_done"}, 64'(bus.complete), 64'd1);
    check({tag, "_q"}, 64'(bus.quotient), 64'(eq));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
    last_q   = eq;
    last_ovf = eo;
  endtask

  task automatic do_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int hold);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    repeat (hold) @(negedge clk);
    check({tag, "_ld"}, 64'(bus.complete), 64'd0);
    bus.start = 1'b0;
    wait_done(tag, a, b);
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    int           sh;
    v  = $urandom;
    sh = $urandom_range(0, N - 2);
    v[N-2:0] = v[N-2:0] >> sh;       // spread magnitudes over many scales
    if ($urandom_range(0, 15) == 0) v[N-2:0] = '0;
    return v;
  endfunction

  initial begin
    rst          = 1'b1;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.start    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", 64'(bus.quotient), 64'd0);
    check("rst_cmp", 64'(bus.complete), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    rst      = 1'b0;
    last_q   = '0;
    last_ovf = 1'b0;

    // Directed cases
    do_div("basic",  32'h0020_1000, 32'h0001_0000, 10);
    check("basic_lit", 64'(bus.quotient), 64'h0010_0800);
    do_div("neg",    32'h8003_0000, 32'h0001_0000, 1);
    check("neg_lit", 64'(bus.quotient), 64'h8001_8000);
    do_div("negneg", 32'h8003_0000, 32'h8001_0000, 1);
    check("negneg_lit", 64'(bus.quotient), 64'h0001_8000);
    do_div("third",  32'h0000_8000, 32'h0001_8000, 2);
    check("third_lit", 64'(bus.quotient), 64'h0000_2AAA);
    do_div("zero",   32'h0000_0000, 32'h8001_0000, 1);
    check("zero_lit", 64'(bus.quotient), 64'h0000_0000);
    do_div("negz",   32'h8000_0000, 32'h0001_0000, 1);
    do_div("div0",   32'h0002_8000, 32'h0000_0000, 1);
    check("div0_lit", 64'(bus.quotient), 64'h7FFF_FFFF);
    check("div0_ovf_lit", 64'(bus.overflow), 64'd1);
    do_div("div0n",  32'h8002_8000, 32'h8000_0000, 1);
    do_div("sat",    32'h7FFF_8000, 32'h0000_4000, 1);
    check("sat_lit", 64'(bus.quotient), 64'h7FFF_FFFF);
    do_div("satneg", 32'h7FFF_8000, 32'h8000_4000, 1);

    // Hold: inputs change without start, results must not move.
    bus.dividend = 32'h1234_5678;
    bus.divisor  = 32'h0000_0003;
    repeat (30) @(negedge clk);
    check("hold_q", 64'(bus.quotient), 64'(last_q));
    check("hold_cmp", 64'(bus.complete), 64'd1);
    check("hold_ovf", 64'(bus.overflow), 64'(last_ovf));

    // Restart at iteration 20 with new operands.
    bus.dividend = 32'h0020_1000;
    bus.divisor  = 32'h0001_0000;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    bus.dividend = 32'h8000_8000;
    bus.divisor  = 32'h0001_8000;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rs_cmp", 64'(bus.complete), 64'd0);
    wait_done("restart", 32'h8000_8000, 32'h0001_8000);

    // Reset mid-operation.
    bus.dividend = 32'h0003_0000;
    bus.divisor  = 32'h0000_4000;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_q", 64'(bus.quotient), 64'd0);
    check("mrst_cmp", 64'(bus.complete), 64'd0);
    check("mrst_ovf", 64'(bus.overflow), 64'd0);
    repeat (LAT + 5) @(negedge clk);
    check("mrst_lost", 64'(bus.complete), 64'd0);
    last_q   = '0;
    last_ovf = 1'b0;

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      do_div($sformatf("rnd%0d", i), rand_op(), rand_op(), $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
